// File: rtl/scrambler_seq_ctrl_pkg.sv
// rtl/scrambler_seq_ctrl_pkg.sv - shared types and defaults for the scrambler run sequencer
package scrambler_seq_ctrl_pkg;

   localparam int DEF_W     = 5;
   localparam int DEF_LEN_W = 4;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_CLEAR = 2'd1,
      ST_RUN   = 2'd2,
      ST_CHECK = 2'd3
   } state_e;

   localparam logic [DEF_W-1:0] SIG_ZERO = '0;

endpackage

// File: rtl/scrambler_seq_ctrl_core.sv
// rtl/scrambler_seq_ctrl_core.sv - input/output scrambler chains with synchronous clear and enable
module scrambler_core
   import scrambler_seq_ctrl_pkg::*;
#(
   parameter int W = DEF_W
)(
   input  logic         clk,
   input  logic         rst,
   input  logic         clr,
   input  logic         en,
   input  logic [W-1:0] x,
   output logic [W-1:0] a,
   output logic [W-1:0] b,
   output logic [W-1:0] a_nxt,
   output logic [W-1:0] b_nxt
);

   // Chain element i sits in vector bit W-1-i, so a right shift moves element i-1 into i
   // and bit 0 is the last element, whose feedback enters elements 0 and 1.
   localparam logic [W-1:0] TAPS = W'(3) << (W - 2);

   always_comb begin
      a_nxt = x ^ (a >> 1) ^ (TAPS & {W{a[0]}});
      b_nxt = ~a ^ (b >> 1) ^ (TAPS & {W{b[0]}});
   end

   always_ff @(posedge clk) begin
      if (rst || clr) begin
         a <= '0;
         b <= '0;
      end else if (en) begin
         a <= a_nxt;
         b <= b_nxt;
      end
   end

endmodule

// File: rtl/scrambler_seq_ctrl.sv
// rtl/scrambler_seq_ctrl.sv - sequences a scrambler run (clear, run len cycles, compare signatures)
module scrambler_seq_ctrl
   import scrambler_seq_ctrl_pkg::*;
#(
   parameter int W     = DEF_W,
   parameter int LEN_W = DEF_LEN_W
)(
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             abort,
   input  logic             mode_cnt,
   input  logic [W-1:0]     base,
   input  logic [LEN_W-1:0] len,
   input  logic [W-1:0]     exp_in,
   input  logic [W-1:0]     exp_out,
   output logic             busy,
   output logic             done,
   output logic             pass,
   output logic             err,
   output logic [W-1:0]     sig_in,
   output logic [W-1:0]     sig_out
);

   localparam logic [W-1:0] ZERO_W = W'(SIG_ZERO);

   state_e           state;
   logic [LEN_W-1:0] run_k;

   logic             cfg_mode;
   logic [W-1:0]     cfg_base;
   logic [LEN_W-1:0] cfg_len;
   logic [W-1:0]     cfg_exp_in;
   logic [W-1:0]     cfg_exp_out;

   logic             in_clear;
   logic             in_run;
   logic             abort_hit;
   logic             run_last;
   logic             start_ok;
   logic             start_bad;

   logic             core_clr;
   logic             core_en;
   logic [W-1:0]     core_x;
   logic [W-1:0]     chain_a;
   logic [W-1:0]     chain_b;
   logic [W-1:0]     chain_a_nxt;
   logic [W-1:0]     chain_b_nxt;

   assign busy = (state != ST_IDLE);

   always_comb begin
      in_clear  = (state == ST_CLEAR);
      in_run    = (state == ST_RUN);
      abort_hit = abort && (in_clear || in_run);
      run_last  = in_run && (run_k == (cfg_len - LEN_W'(1)));
      start_ok  = (state == ST_IDLE) && start && (len != '0);
      start_bad = (state == ST_IDLE) && start && (len == '0);
      core_clr  = in_clear;
      // An aborted RUN cycle must not advance the chains so the captured signature matches them.
      core_en   = in_run && !abort;
      core_x    = ZERO_W;
      if (in_run) begin
         core_x = cfg_mode ? (cfg_base + W'(run_k)) : cfg_base;
      end
   end

   scrambler_core #(
      .W (W)
   ) u_core (
      .clk   (clk),
      .rst   (rst),
      .clr   (core_clr),
      .en    (core_en),
      .x     (core_x),
      .a     (chain_a),
      .b     (chain_b),
      .a_nxt (chain_a_nxt),
      .b_nxt (chain_b_nxt)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= ST_IDLE;
         run_k       <= '0;
         cfg_mode    <= 1'b0;
         cfg_base    <= '0;
         cfg_len     <= '0;
         cfg_exp_in  <= '0;
         cfg_exp_out <= '0;
         done        <= 1'b0;
         pass        <= 1'b0;
         err         <= 1'b0;
         sig_in      <= ZERO_W;
         sig_out     <= ZERO_W;
      end else begin
         done <= 1'b0;
         if (abort_hit) begin
            state   <= ST_IDLE;
            done    <= 1'b1;
            err     <= 1'b1;
            pass    <= 1'b0;
            sig_in  <= chain_a;
            sig_out <= chain_b;
         end else begin
            case (state)
               ST_IDLE: begin
                  if (start_bad) begin
                     done <= 1'b1;
                     err  <= 1'b1;
                     pass <= 1'b0;
                  end else if (start_ok) begin
                     cfg_mode    <= mode_cnt;
                     cfg_base    <= base;
                     cfg_len     <= len;
                     cfg_exp_in  <= exp_in;
                     cfg_exp_out <= exp_out;
                     pass        <= 1'b0;
                     err         <= 1'b0;
                     state       <= ST_CLEAR;
                  end
               end
               ST_CLEAR: begin
                  run_k <= '0;
                  state <= ST_RUN;
               end
               ST_RUN: begin
                  // Results are taken from the post-update chains so done lines up with CHECK.
                  if (run_last) begin
                     state   <= ST_CHECK;
                     done    <= 1'b1;
                     err     <= 1'b0;
                     pass    <= (chain_a_nxt == cfg_exp_in) && (chain_b_nxt == cfg_exp_out);
                     sig_in  <= chain_a_nxt;
                     sig_out <= chain_b_nxt;
                  end else begin
                     run_k <= run_k + LEN_W'(1);
                  end
               end
               ST_CHECK: begin
                  state <= ST_IDLE;
               end
               default: begin
                  state <= ST_IDLE;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_scrambler_seq_ctrl.sv
// tb/tb_scrambler_seq_ctrl.sv - scoreboard bench for the scrambler run sequencer
module tb_scrambler_seq_ctrl;

   logic       clk = 1'b0;
   logic       rst;
   logic       start;
   logic       abort;
   logic       mode_cnt;
   logic [4:0] base;
   logic [3:0] len;
   logic [4:0] exp_in;
   logic [4:0] exp_out;
   logic       busy;
   logic       done;
   logic       pass;
   logic       err;
   logic [4:0] sig_in;
   logic [4:0] sig_out;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   typedef struct {
      logic       pass;
      logic       err;
      logic       chk_sig;
      logic [4:0] si;
      logic [4:0] so;
      int         due;
   } exp_t;

   exp_t sb[$];

   scrambler_seq_ctrl #(
      .W     (5),
      .LEN_W (4)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .start    (start),
      .abort    (abort),
      .mode_cnt (mode_cnt),
      .base     (base),
      .len      (len),
      .exp_in   (exp_in),
      .exp_out  (exp_out),
      .busy     (busy),
      .done     (done),
      .pass     (pass),
      .err      (err),
      .sig_in   (sig_in),
      .sig_out  (sig_out)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      if (obs !== expv) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, expv, cyc);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Element i of a chain is bit 4-i of the printed vector (element 0 is the MSB).
   function automatic void model(input logic m, input logic [4:0] bv, input int steps,
                                 output logic [4:0] ao, output logic [4:0] bo);
      logic       a [5];
      logic       b [5];
      logic       na [5];
      logic       nb [5];
      logic       x [5];
      logic [4:0] xv;
      for (int i = 0; i < 5; i++) begin
         a[i] = 1'b0;
         b[i] = 1'b0;
      end
      for (int k = 0; k < steps; k++) begin
         xv = m ? (bv + 5'(k)) : bv;
         for (int i = 0; i < 5; i++) x[i] = xv[4-i];
         na[0] = x[0] ^ a[4];
         na[1] = x[1] ^ a[0] ^ a[4];
         nb[0] = !a[0] ^ b[4];
         nb[1] = !a[1] ^ b[0] ^ b[4];
         for (int i = 2; i < 5; i++) begin
            na[i] = x[i] ^ a[i-1];
            nb[i] = !a[i] ^ b[i-1];
         end
         a = na;
         b = nb;
      end
      for (int i = 0; i < 5; i++) begin
         ao[4-i] = a[i];
         bo[4-i] = b[i];
      end
   endfunction

   always @(negedge clk) begin
      exp_t e;
      if (done === 1'b1) begin
         if (sb.size() == 0) begin
            check_val("unexpected_done", {31'b0, done}, 32'd0);
         end else begin
            e = sb.pop_front();
            check_val("done_cycle", cyc, e.due);
            check_val("pass", {31'b0, pass}, {31'b0, e.pass});
            check_val("err", {31'b0, err}, {31'b0, e.err});
            if (e.chk_sig) begin
               check_val("sig_in", {27'b0, sig_in}, {27'b0, e.si});
               check_val("sig_out", {27'b0, sig_out}, {27'b0, e.so});
            end
         end
      end
   end

   task automatic drive_start(input logic m, input logic [4:0] b, input logic [3:0] l,
                              input logic [4:0] ei, input logic [4:0] eo,
                              input logic push, input logic ep, input logic ee,
                              input logic cs, input logic [4:0] si, input logic [4:0] so,
                              input int lat);
      exp_t e;
      start    = 1'b1;
      mode_cnt = m;
      base     = b;
      len      = l;
      exp_in   = ei;
      exp_out  = eo;
      if (push) begin
         e.pass    = ep;
         e.err     = ee;
         e.chk_sig = cs;
         e.si      = si;
         e.so      = so;
         e.due     = cyc + lat;
         sb.push_back(e);
      end
      tick();
      start = 1'b0;
   endtask

   task automatic model_start(input logic m, input logic [4:0] b, input logic [3:0] l,
                              input logic [4:0] ei, input logic [4:0] eo);
      logic [4:0] ma;
      logic [4:0] mb;
      model(m, b, int'(l), ma, mb);
      drive_start(m, b, l, ei, eo, 1'b1, (ma == ei) && (mb == eo), 1'b0, 1'b1, ma, mb,
                  int'(l) + 2);
   endtask

   task automatic wait_drain(input string tag, input int budget);
      int n = 0;
      while ((sb.size() != 0 || busy !== 1'b0) && n < budget) begin
         tick();
         n++;
      end
      if (n >= budget) check_val({tag, "_timeout"}, sb.size(), 32'd0);
   endtask

   task automatic check_all_zero(input string tag);
      check_val({tag, "_busy"}, {31'b0, busy}, 32'd0);
      check_val({tag, "_done"}, {31'b0, done}, 32'd0);
      check_val({tag, "_pass"}, {31'b0, pass}, 32'd0);
      check_val({tag, "_err"}, {31'b0, err}, 32'd0);
      check_val({tag, "_sig_in"}, {27'b0, sig_in}, 32'd0);
      check_val({tag, "_sig_out"}, {27'b0, sig_out}, 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not finish (cycle %0d)", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      logic [4:0] ma;
      logic [4:0] mb;
      logic [4:0] rb;
      logic [3:0] rl;
      logic       rm;
      rst      = 1'b1;
      start    = 1'b0;
      abort    = 1'b0;
      mode_cnt = 1'b0;
      base     = '0;
      len      = '0;
      exp_in   = '0;
      exp_out  = '0;
      tick();
      tick();
      rst = 1'b0;
      check_all_zero("reset");
      tick();

      // counting run, matching signatures
      drive_start(1'b1, 5'd0, 4'd10, 5'b11001, 5'b01001, 1'b1, 1'b1, 1'b0, 1'b1,
                  5'b11001, 5'b01001, 12);
      check_val("busy_clear", {31'b0, busy}, 32'd1);
      wait_drain("count_pass", 40);

      // counting run, wrong expected output signature
      drive_start(1'b1, 5'd0, 4'd10, 5'b11001, 5'b01011, 1'b1, 1'b0, 1'b0, 1'b1,
                  5'b11001, 5'b01001, 12);
      wait_drain("count_miss", 40);

      // hold mode, single run cycle
      drive_start(1'b0, 5'd0, 4'd1, 5'b00000, 5'b11111, 1'b1, 1'b1, 1'b0, 1'b1,
                  5'b00000, 5'b11111, 3);
      wait_drain("hold_len1", 40);

      // zero length is rejected without leaving IDLE
      drive_start(1'b1, 5'd3, 4'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b1, 1'b0, 5'd0, 5'd0, 1);
      check_val("reject_busy", {31'b0, busy}, 32'd0);
      tick();
      check_val("reject_busy_after", {31'b0, busy}, 32'd0);
      wait_drain("reject", 10);

      // abort on the fifth RUN cycle: four chain updates have happened
      model(1'b1, 5'd0, 4, ma, mb);
      drive_start(1'b1, 5'd0, 4'd10, 5'b11001, 5'b01001, 1'b1, 1'b0, 1'b1, 1'b1,
                  ma, mb, 7);
      repeat (5) tick();
      abort = 1'b1;
      tick();
      abort = 1'b0;
      check_val("abort_busy", {31'b0, busy}, 32'd0);
      wait_drain("abort", 10);

      // reset on the third RUN cycle: no done, everything zero
      drive_start(1'b1, 5'd0, 4'd10, 5'b11001, 5'b01001, 1'b0, 1'b0, 1'b0, 1'b0,
                  5'd0, 5'd0, 0);
      repeat (3) tick();
      rst   = 1'b1;
      abort = 1'b1;
      start = 1'b1;
      tick();
      rst   = 1'b0;
      abort = 1'b0;
      start = 1'b0;
      check_all_zero("midrun_rst");
      repeat (15) tick();
      drive_start(1'b1, 5'd0, 4'd10, 5'b11001, 5'b01001, 1'b1, 1'b1, 1'b0, 1'b1,
                  5'b11001, 5'b01001, 12);
      wait_drain("after_rst", 40);

      // start in the same IDLE cycle as a reject done is accepted
      drive_start(1'b0, 5'd9, 4'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b1, 1'b0, 5'd0, 5'd0, 1);
      model_start(1'b1, 5'b10100, 4'd3, 5'd0, 5'd0);
      wait_drain("back_to_back", 40);

      // start and config changes during a run are ignored
      model(1'b0, 5'b10110, 6, ma, mb);
      model_start(1'b0, 5'b10110, 4'd6, ma, mb);
      tick();
      check_val("busy_run", {31'b0, busy}, 32'd1);
      start    = 1'b1;
      mode_cnt = 1'b1;
      base     = 5'b00011;
      len      = 4'd2;
      exp_in   = 5'd0;
      tick();
      tick();
      start = 1'b0;
      wait_drain("busy_ignore", 40);

      for (int i = 0; i < 8; i++) begin
         rm = 1'($urandom_range(0, 1));
         rb = 5'($urandom);
         rl = 4'($urandom_range(1, 15));
         model(rm, rb, int'(rl), ma, mb);
         if (i % 2 == 0) model_start(rm, rb, rl, ma, mb);
         else            model_start(rm, rb, rl, 5'($urandom), mb);
         wait_drain("random", 40);
      end

      tick();
      check_val("sb_final", sb.size(), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/scrambler_seq_ctrl.md
SCRAMBLER_SEQ_CTRL -- requirements
Module: scrambler_seq_ctrl

Interface
REQ-001 Parameter W, default 5: width of the scrambler input, input-chain and output-chain vectors.
REQ-002 Parameter LEN_W, default 4: width of the run-length field; maximum run is 2**LEN_W-1 cycles.
REQ-003 clk  input  1  sole clock; all state changes on posedge clk.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 start  input  1  request a run; sampled only in IDLE.
REQ-006 abort  input  1  terminate a run in progress.
REQ-007 mode_cnt  input  1  1 = drive base+k on run cycle k; 0 = drive base constantly.
REQ-008 base  input  W  first or constant scrambler input value.
REQ-009 len  input  LEN_W  number of RUN cycles.
REQ-010 exp_in, exp_out  input  W each  expected input-chain and output-chain signatures.
REQ-011 busy  output  1  high in CLEAR, RUN and CHECK.
REQ-012 done  output  1  one-cycle completion pulse.
REQ-013 pass  output  1  result; valid while done=1, held until next accepted start.
REQ-014 err  output  1  run rejected (len=0) or aborted; valid with done.
REQ-015 sig_in, sig_out  output  W each  captured chain states; valid with done and held until next accepted start.

Function
REQ-016 Config fields (mode_cnt, base, len, exp_in, exp_out) latched on the cycle start is accepted; later changes ignored until the next accepted start.
REQ-017 FSM states: IDLE, CLEAR, RUN, CHECK; no other states.
REQ-018 IDLE with start=1 and len!=0 -> CLEAR; with start=1 and len=0 -> stay IDLE, pulse done with err=1, pass=0.
REQ-019 CLEAR lasts one cycle; the core chains are zeroed synchronously; then -> RUN with k=0.
REQ-020 RUN lasts exactly len cycles; on cycle k the core input is base+k modulo 2**W (count mode) or base (hold mode); after cycle len-1 -> CHECK.
REQ-021 Core update per RUN cycle, bit 0 = MSB: a0'=x0^a4; a1'=x1^a0^a4; a2'=x2^a1; a3'=x3^a2; a4'=x4^a3; b0'=!a0^b4; b1'=!a1^b0^b4; b2'=!a2^b1; b3'=!a3^b2; b4'=!a4^b3 (x = core input, a = input chain, b = output chain, right-hand sides use pre-edge values).
REQ-022 Core state held outside RUN and CLEAR.
REQ-023 CHECK lasts one cycle: sig_in/sig_out capture the chains, pass = (a==exp_in)&&(b==exp_out), done=1, err=0; then -> IDLE.
REQ-024 Latency: start accepted at cycle T -> done at cycle T+len+2; start asserted during busy is ignored, no queuing.
REQ-025 abort in CLEAR or RUN: next cycle done=1, err=1, pass=0, sig_* capture current chains, -> IDLE; abort in CHECK or IDLE ignored.
REQ-026 start and done in the same IDLE cycle: the new start is accepted (a CHECK-cycle done is followed by IDLE).
REQ-027 Core input driven to 0 outside RUN.

Reset
REQ-028 rst=1 at a posedge: state IDLE, core chains zero, busy=0, done=0, pass=0, err=0, sig_in=0, sig_out=0, latched config zero.
REQ-029 rst mid-run overrides abort and start; no done pulse is produced for the interrupted run.

Structure
REQ-030 Shared package holds the FSM state enum, W and LEN_W defaults, and the zero signature constant.
REQ-031 One sub-module, scrambler_core: the two W-bit chains of REQ-021 with synchronous clear and enable; the controller instantiates exactly one.

Verification
REQ-032 count mode, base=0, len=10, exp_in=11001, exp_out=01001, start pulse -> done 12 cycles later, pass=1, sig_in=11001, sig_out=01001.
REQ-033 same as REQ-032 but exp_out=01011 -> done, pass=0, err=0, sig_out=01001.
REQ-034 hold mode, base=00000, len=1 -> done 3 cycles after start, sig_in=00000, sig_out=11111.
REQ-035 len=0 with start -> done next cycle, err=1, busy never asserted.
REQ-036 REQ-032 run with abort on the 5th RUN cycle -> done next cycle, err=1, pass=0, busy=0 after.
REQ-037 rst asserted on the 3rd RUN cycle -> all outputs zero next cycle, no done; a fresh REQ-032 run then passes.
